pds_trace_monitor: RTL and testbench

Synthesizable, parametrised successor to the single-channel req/fault/gnt sampling monitor. It snapshots NUM_CH channels of req/fault/gnt with a timestamp and stores each snapshot as an entry in an internal FIFO. Entries are written every cycle or only on change, selected by a mode pin. It also flags grant-without-request protocol errors per channel. It sits beside the PDS arbiter and is drained by a CSR/debug reader through a valid/ready port.

---
 rtl/pds_trace_pkg.sv | 31 +++
 rtl/pds_trace_fifo.sv | 59 +++++
 rtl/pds_trace_monitor.sv | 164 ++++++++++++++++
 tb/tb_pds_trace_monitor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pds_trace_pkg.sv
// pds_trace_pkg: shared definitions for the PDS trace monitor.
//   entry_w()   - width of one FIFO entry {ts, fault, gnt, req}
//   REQ_LSB     - bit offset of the req field inside an entry
//   gnt_lsb(), fault_lsb(), ts_lsb() - field offsets for a given channel count
//   pds_trc_mode_e - capture mode (every enabled cycle or only on change)
package pds_trace_pkg;

  localparam int REQ_LSB = 0;

  typedef enum logic {
    PDS_TRC_ALL    = 1'b0,
    PDS_TRC_CHANGE = 1'b1
  } pds_trc_mode_e;

  function automatic int entry_w(input int num_ch, input int ts_w);
    return ts_w + 3 * num_ch;
  endfunction

  function automatic int gnt_lsb(input int num_ch);
    return num_ch;
  endfunction

  function automatic int fault_lsb(input int num_ch);
    return 2 * num_ch;
  endfunction

  function automatic int ts_lsb(input int num_ch);
    return 3 * num_ch;
  endfunction

endpackage

// File: rtl/pds_trace_fifo.sv
// pds_trace_fifo: first-word-fall-through synchronous FIFO.
//   clk, rst_n - clock, asynchronous active-low reset
//   flush      - synchronous empty; wins over push and pop
//   push, din  - write request and data (accepted if not full, or full with a pop)
//   pop        - remove head entry (ignored when empty)
//   dout       - head entry, valid whenever empty is low
//   full, empty, level - occupancy status
module pds_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_pop;
  logic             do_push;

  // Pointers carry one extra MSB: equal low bits with differing MSBs means full.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = wptr - rptr;
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer update; flush simply collapses both pointers to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pds_trace_monitor.sv
// pds_trace_monitor: multi-channel req/fault/gnt trace capture.
//   clk, rst_n         - clock, asynchronous active-low reset
//   req, fault, gnt    - NUM_CH monitored channel signals
//   enable             - capture enable (also gates the timestamp)
//   change_only        - 1: record only when the snapshot differs from the last one
//   clr                - synchronous clear of FIFO, timestamp, error and overflow state
//   out_valid/ready    - FWFT drain port, out_data = {ts, fault, gnt, req}
//   level              - FIFO occupancy
//   overflow, ovf_cnt  - sticky drop flag and saturating drop count
//   gnt_err            - sticky per-channel grant-without-request flag
module pds_trace_monitor
  import pds_trace_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int OVF_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH-1:0]         fault,
  input  logic [NUM_CH-1:0]         gnt,
  input  logic                      enable,
  input  logic                      change_only,
  input  logic                      clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_W+3*NUM_CH-1:0]  out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [OVF_W-1:0]          ovf_cnt,
  output logic [NUM_CH-1:0]         gnt_err
);

  localparam int EW        = entry_w(NUM_CH, TS_W);
  localparam int GNT_LSB   = gnt_lsb(NUM_CH);
  localparam int FAULT_LSB = fault_lsb(NUM_CH);
  localparam int TS_LSB    = ts_lsb(NUM_CH);

  logic [TS_W-1:0]     ts;
  logic                s_vld;
  logic [TS_W-1:0]     s_ts;
  logic [NUM_CH-1:0]   s_req;
  logic [NUM_CH-1:0]   s_gnt;
  logic [NUM_CH-1:0]   s_fault;
  logic [3*NUM_CH-1:0] prev_snap;
  logic                prev_valid;
  logic [EW-1:0]       w_entry;
  pds_trc_mode_e       mode;
  logic                cand;
  logic                pop;
  logic                full;
  logic                empty;
  logic                drop;

  assign mode = pds_trc_mode_e'(change_only);

  // Stage W decision: the first sample of a run always records, after that
  // change mode only records when the channel snapshot (not the ts) differs.
  assign cand = s_vld && ((mode == PDS_TRC_ALL) || !prev_valid ||
                          ({s_fault, s_gnt, s_req} != prev_snap));

  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign drop      = cand && full && !pop && !clr;

  always_comb begin
    w_entry = '0;
    w_entry[REQ_LSB   +: NUM_CH] = s_req;
    w_entry[GNT_LSB   +: NUM_CH] = s_gnt;
    w_entry[FAULT_LSB +: NUM_CH] = s_fault;
    w_entry[TS_LSB    +: TS_W]   = s_ts;
  end

  // Timestamp free-runs while enabled and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (clr) begin
      ts <= '0;
    end else if (enable) begin
      ts <= ts + 1'b1;
    end
  end

  // Stage S: snapshot the channels and timestamp; clr discards the in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_vld   <= 1'b0;
      s_ts    <= '0;
      s_req   <= '0;
      s_gnt   <= '0;
      s_fault <= '0;
    end else if (clr) begin
      s_vld <= 1'b0;
    end else begin
      s_vld <= enable;
      if (enable) begin
        s_ts    <= ts;
        s_req   <= req;
        s_gnt   <= gnt;
        s_fault <= fault;
      end
    end
  end

  // Last-recorded-snapshot tracking; dropping enable forgets it so the next
  // run starts with a guaranteed entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      prev_snap  <= '0;
    end else if (clr) begin
      prev_valid <= 1'b0;
    end else begin
      if (s_vld) prev_snap <= {s_fault, s_gnt, s_req};
      if (!enable)    prev_valid <= 1'b0;
      else if (s_vld) prev_valid <= 1'b1;
    end
  end

  // Sticky protocol error, evaluated on each captured sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_err <= '0;
    end else if (clr) begin
      gnt_err <= '0;
    end else if (enable) begin
      gnt_err <= gnt_err | (gnt & ~req);
    end
  end

  // Drop accounting: overflow is sticky, ovf_cnt saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end else if (clr) begin
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  pds_trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (cand && !clr),
    .din   (w_entry),
    .pop   (pop && !clr),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_pds_trace_monitor.sv
// tb_pds_trace_monitor: scoreboard bench for pds_trace_monitor (NUM_CH=4,
// DEPTH=16, TS_W=4, OVF_W=8). Stimulus pushes hand-computed entries into a
// queue; a negedge monitor pops and compares every entry the DUT hands over.
module tb_pds_trace_monitor;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 4;
  localparam int OVF_W  = 8;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] fault;
  logic [NUM_CH-1:0] gnt;
  logic              enable;
  logic              change_only;
  logic              clr;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [4:0]        level;
  logic              overflow;
  logic [OVF_W-1:0]  ovf_cnt;
  logic [NUM_CH-1:0] gnt_err;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  pds_trace_monitor #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W),
    .OVF_W  (OVF_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .fault       (fault),
    .gnt         (gnt),
    .enable      (enable),
    .change_only (change_only),
    .clr         (clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .overflow    (overflow),
    .ovf_cnt     (ovf_cnt),
    .gnt_err     (gnt_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected entry {ts, fault, gnt, req}; ts wraps at 16.
  function automatic logic [15:0] mk(input int t, input logic [3:0] f,
                                     input logic [3:0] g, input logic [3:0] r);
    logic [3:0] tt;
    tt = 4'(t % 16);
    return {tt, f, g, r};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic en, input logic co, input logic [3:0] r,
                               input logic [3:0] f, input logic [3:0] g,
                               input logic rdy);
    enable      = en;
    change_only = co;
    req         = r;
    fault       = f;
    gnt         = g;
    out_ready   = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  // Monitor: whatever the DUT pops at the next edge must match the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_entry: got %0h expected none", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("[TB] FAIL entry: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(2);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_level",     32'(level),     32'd0);
    checkOutput("rst_overflow",  32'(overflow),  32'd0);
    checkOutput("rst_ovf_cnt",   32'(ovf_cnt),   32'd0);
    checkOutput("rst_gnt_err",   32'(gnt_err),   32'd0);
    rst_n = 1'b1;

    // Every-cycle capture of a constant pattern, held in the FIFO.
    applyStimulus(1'b1, 1'b0, 4'hA, 4'h1, 4'h2, 1'b0);
    step(5);
    applyStimulus(1'b0, 1'b0, 4'hA, 4'h1, 4'h2, 1'b0);
    step(1);
    checkOutput("t1_level",     32'(level),     32'd5);
    checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(i, 4'h1, 4'h2, 4'hA));
    applyStimulus(1'b0, 1'b0, 4'hA, 4'h1, 4'h2, 1'b1);
    step(5);
    checkOutput("t1_drained", 32'(level), 32'd0);

    // Change-only: repeated snapshot is suppressed.
    doClear();
    exp_q.push_back(mk(0, 4'h0, 4'h0, 4'h0));
    exp_q.push_back(mk(1, 4'h0, 4'h0, 4'h1));
    exp_q.push_back(mk(3, 4'h0, 4'h0, 4'h3));
    applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1); step(1);
    applyStimulus(1'b1, 1'b1, 4'h1, 4'h0, 4'h0, 1'b1); step(1);
    applyStimulus(1'b1, 1'b1, 4'h1, 4'h0, 4'h0, 1'b1); step(1);
    applyStimulus(1'b1, 1'b1, 4'h3, 4'h0, 4'h0, 1'b1); step(1);
    applyStimulus(1'b0, 1'b1, 4'h3, 4'h0, 4'h0, 1'b1); step(3);
    checkOutput("t2_level",   32'(level),        32'd0);
    checkOutput("t2_entries", 32'(exp_q.size()), 32'd0);

    // Overflow: 20 candidates into 16 slots, then drain while capturing.
    doClear();
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(i, 4'h0, 4'h4, 4'h5));
    for (int i = 20; i < 25; i++) exp_q.push_back(mk(i, 4'h0, 4'h4, 4'h5));
    applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 4'h4, 1'b0);
    step(21);
    checkOutput("t3_level_full", 32'(level),    32'd16);
    checkOutput("t3_overflow",   32'(overflow), 32'd1);
    checkOutput("t3_ovf_cnt",    32'(ovf_cnt),  32'd4);
    applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 4'h4, 1'b1);
    step(4);
    checkOutput("t3_level_hold", 32'(level),   32'd16);
    checkOutput("t3_ovf_hold",   32'(ovf_cnt), 32'd4);
    applyStimulus(1'b0, 1'b0, 4'h5, 4'h0, 4'h4, 1'b1);
    step(18);
    checkOutput("t3_drained", 32'(level),        32'd0);
    checkOutput("t3_entries", 32'(exp_q.size()), 32'd0);

    // Drop counter saturation: 258 drops clamp at 255.
    doClear();
    applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 4'h4, 1'b0);
    step(275);
    checkOutput("sat_ovf_cnt", 32'(ovf_cnt), 32'd255);
    checkOutput("sat_level",   32'(level),   32'd16);

    // Clear wipes FIFO and overflow state; then grant-without-request.
    doClear();
    checkOutput("clr_level",     32'(level),     32'd0);
    checkOutput("clr_out_valid", 32'(out_valid), 32'd0);
    checkOutput("clr_overflow",  32'(overflow),  32'd0);
    checkOutput("clr_ovf_cnt",   32'(ovf_cnt),   32'd0);
    exp_q.push_back(mk(0, 4'h0, 4'h4, 4'h0));
    exp_q.push_back(mk(1, 4'h0, 4'h0, 4'h0));
    exp_q.push_back(mk(2, 4'h0, 4'h0, 4'h0));
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h4, 1'b1); step(1);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1); step(2);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1); step(3);
    checkOutput("t4_gnt_err_sticky", 32'(gnt_err), 32'h4);
    checkOutput("t4_entries",        32'(exp_q.size()), 32'd0);
    doClear();
    checkOutput("t4_gnt_err_clr", 32'(gnt_err), 32'd0);
    checkOutput("t4_level_clr",   32'(level),   32'd0);

    // Timestamp wrap 15 -> 0 in recorded entries.
    doClear();
    for (int i = 0; i < 17; i++) exp_q.push_back(mk(i, 4'h8, 4'h1, 4'h3));
    applyStimulus(1'b1, 1'b0, 4'h3, 4'h8, 4'h1, 1'b1);
    step(17);
    applyStimulus(1'b0, 1'b0, 4'h3, 4'h8, 4'h1, 1'b1);
    step(3);
    checkOutput("t5_level",   32'(level),        32'd0);
    checkOutput("t5_entries", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with a partly filled FIFO.
    doClear();
    applyStimulus(1'b1, 1'b0, 4'h6, 4'h0, 4'h1, 1'b0);
    step(7);
    applyStimulus(1'b0, 1'b0, 4'h6, 4'h0, 4'h1, 1'b0);
    step(1);
    checkOutput("t6_level_pre",   32'(level),   32'd7);
    checkOutput("t6_gnt_err_pre", 32'(gnt_err), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_level",     32'(level),     32'd0);
    checkOutput("t6_rst_gnt_err",   32'(gnt_err),   32'd0);
    step(2);
    rst_n = 1'b1;
    exp_q.push_back(mk(0, 4'h0, 4'h0, 4'h2));
    applyStimulus(1'b1, 1'b1, 4'h2, 4'h0, 4'h0, 1'b1); step(1);
    applyStimulus(1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 1'b1); step(3);
    checkOutput("t6_post_level", 32'(level),        32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
